// File: rtl/mux4_serializer_pkg.sv
// Shared definitions for the 4:1 mux serializer.
// Contents:
//   BITS_PER_WORD - number of serial bits emitted per parallel word (4)
//   state_e       - serializer FSM state (IDLE: buffer empty, SHIFT: buffer holds a word)
//   bit_sel()     - maps the running bit counter onto the mux select for a given bit order
//   ptr_inc()     - wrap-around increment for buffer pointers of a given depth
package mux4_serializer_pkg;

  localparam int BITS_PER_WORD = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // LSB-first walks A0..A3; MSB-first walks A3..A0 off the same counter.
  function automatic logic [1:0] bit_sel(input logic [1:0] cnt, input logic msb_first);
    return msb_first ? (2'd3 - cnt) : cnt;
  endfunction

  // Pointers wrap at the configured depth, not at the 2-bit field limit.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr, input int depth);
    return (int'(ptr) >= depth - 1) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/mux4_serializer_if.sv
// Bus bundle between the serializer and its neighbours.
// Signals:
//   D[3:0] - parallel word (D[n] feeds mux input An)
//   DV/DR  - upstream valid / ready
//   Q      - registered serial bit
//   QV/QR  - downstream valid / ready
//   QL     - Q is the last bit of its word
//   SL0/1  - current mux select (observation only)
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. The producer holds data steady while valid=1 and
// ready=0; ready never depends combinationally on valid.
// Modports: master = the word source / bit sink, slave = the serializer.
interface mux4_serializer_if;
  logic [3:0] D;
  logic       DV;
  logic       DR;
  logic       Q;
  logic       QV;
  logic       QL;
  logic       QR;
  logic       SL0;
  logic       SL1;

  modport master (
    output D, DV, QR,
    input  DR, Q, QV, QL, SL0, SL1
  );

  modport slave (
    input  D, DV, QR,
    output DR, Q, QV, QL, SL0, SL1
  );
endinterface

// File: rtl/HDMUX4DL.sv
// 4:1 one-bit mux cell.
// Ports:
//   A0..A3 - data inputs
//   S0, S1 - select, {S1,S0} picks An
//   Z      - selected data output
module HDMUX4DL (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic S0,
  input  logic S1,
  output logic Z
);

  always_comb begin
    Z = A0;
    case ({S1, S0})
      2'd0: Z = A0;
      2'd1: Z = A1;
      2'd2: Z = A2;
      2'd3: Z = A3;
      default: Z = A0;
    endcase
  end

endmodule

// File: rtl/mux4_serializer.sv
// 4-bit parallel to 1-bit serial converter with a small word FIFO in front.
// Words are accepted on DV/DR, buffered (DEPTH entries, legal 1..4), and each
// word is shifted out through a 4:1 mux cell as four registered bits on QV/QR,
// with QL flagging the fourth bit. Consecutive words stream with no bubble.
// Parameters:
//   DEPTH     - buffered words (1..4)
//   MSB_FIRST - 0: bit order A0..A3, 1: bit order A3..A0
// Ports:
//   CK        - clock, rising edge
//   RN        - synchronous active-low reset
//   bus       - serializer side of mux4_serializer_if (D/DV/DR in, Q/QV/QL/QR out, SL0/SL1)
//   dbg_state - current FSM state
module mux4_serializer
  import mux4_serializer_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                CK,
  input  logic                RN,
  mux4_serializer_if.slave    bus,
  output state_e              dbg_state
);

  localparam logic [1:0] LAST_CNT = 2'(BITS_PER_WORD - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        q_q, q_d;
  logic        qv_q, qv_d;
  logic        ql_q, ql_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  // Four slots always exist; only the first DEPTH are ever addressed.
  logic [3:0]  mem_q [4];
  logic [3:0]  mem_d [4];

  logic        dr;
  logic        push;
  logic        issue;
  logic        last;
  logic        pop;
  logic [1:0]  sel;
  logic [3:0]  head;
  logic        mux_z;

  // DR comes only from the registered count, so it has no path from DV or QR.
  assign dr    = (int'(count_q) < DEPTH);
  assign push  = bus.DV && dr;
  // A new bit may be loaded when the output register is empty or being drained.
  assign issue = (state_q == SHIFT) && (!qv_q || bus.QR);
  assign last  = (cnt_q == LAST_CNT);
  assign pop   = issue && last;
  assign sel   = bit_sel(cnt_q, MSB_FIRST);
  assign head  = mem_q[rd_ptr_q];

  HDMUX4DL u_mux (
    .A0 (head[0]),
    .A1 (head[1]),
    .A2 (head[2]),
    .A3 (head[3]),
    .S0 (sel[0]),
    .S1 (sel[1]),
    .Z  (mux_z)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != 3'd0) state_d = SHIFT;
      // Leave only when the final bit of the only buffered word goes out
      // and nothing is arriving to replace it.
      SHIFT:   if (pop && (count_q == 3'd1) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register and bit counter.
  always_comb begin
    q_d   = q_q;
    qv_d  = qv_q;
    ql_d  = ql_q;
    cnt_d = cnt_q;
    if (issue) begin
      q_d   = mux_z;
      qv_d  = 1'b1;
      ql_d  = last;
      cnt_d = cnt_q + 2'd1;
    end else if (qv_q && bus.QR) begin
      qv_d = 1'b0;
    end
  end

  // Word FIFO.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.D;
      wr_ptr_d        = ptr_inc(wr_ptr_q, DEPTH);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q, DEPTH);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      q_q      <= 1'b0;
      qv_q     <= 1'b0;
      ql_q     <= 1'b0;
      count_q  <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qv_q     <= qv_d;
      ql_q     <= ql_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Word storage is plain data; the count and pointers decide what is live.
  always_ff @(posedge CK) begin
    mem_q <= mem_d;
  end

  assign bus.DR    = dr;
  assign bus.Q     = q_q;
  assign bus.QV    = qv_q;
  assign bus.QL    = ql_q;
  assign bus.SL0   = sel[0];
  assign bus.SL1   = sel[1];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux4_serializer.sv
// Bench for mux4_serializer: two instances (A: DEPTH=2 LSB-first, B: DEPTH=1
// MSB-first) driven from one directed/random sequence. A word-level queue
// model turns every accepted word into its expected {last,bit} stream.
module tb_mux4_serializer;
  import mux4_serializer_pkg::*;

  logic   CK;
  logic   RN;
  state_e state_a;
  state_e state_b;

  mux4_serializer_if ia ();
  mux4_serializer_if ib ();

  mux4_serializer #(.DEPTH(2), .MSB_FIRST(1'b0)) u_dut_a (
    .CK(CK), .RN(RN), .bus(ia), .dbg_state(state_a)
  );

  mux4_serializer #(.DEPTH(1), .MSB_FIRST(1'b1)) u_dut_b (
    .CK(CK), .RN(RN), .bus(ib), .dbg_state(state_b)
  );

  // Clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {last, bit} entries per instance.
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];

  // Bit j of a word in transmission order.
  function automatic logic [1:0] word_bit(input logic [3:0] w, input bit msb_first, input int j);
    int idx;
    idx = msb_first ? (3 - j) : j;
    return {(j == 3), w[idx]};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_a(input logic dv, input logic [3:0] d, input logic qr);
    ia.DV = dv; ia.D = d; ia.QR = qr;
  endtask

  task automatic drive_b(input logic dv, input logic [3:0] d, input logic qr);
    ib.DV = dv; ib.D = d; ib.QR = qr;
  endtask

  // Called at a falling edge: records the handshakes that the coming rising
  // edge will perform, then advances to the next falling edge.
  task automatic step();
    logic [1:0] e;
    #1;
    if (!RN) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (ia.QV && ia.QR) begin
        if (exp_a.size() == 0) chk("a_extra_bit", {3'b0, ia.QV}, 4'd0);
        else begin
          e = exp_a.pop_front();
          chk("a_stream", {2'b0, ia.QL, ia.Q}, {2'b0, e});
        end
      end
      if (ia.DV && ia.DR)
        for (int j = 0; j < 4; j++) exp_a.push_back(word_bit(ia.D, 1'b0, j));
      if (ib.QV && ib.QR) begin
        if (exp_b.size() == 0) chk("b_extra_bit", {3'b0, ib.QV}, 4'd0);
        else begin
          e = exp_b.pop_front();
          chk("b_stream", {2'b0, ib.QL, ib.Q}, {2'b0, e});
        end
      end
      if (ib.DV && ib.DR)
        for (int j = 0; j < 4; j++) exp_b.push_back(word_bit(ib.D, 1'b1, j));
    end
    @(negedge CK);
  endtask

  task automatic drain(input string tag);
    drive_a(1'b0, 4'h0, 1'b1);
    drive_b(1'b0, 4'h0, 1'b1);
    for (int c = 0; c < 60 && (exp_a.size() != 0 || exp_b.size() != 0); c++) step();
    step();
    chk({tag, "_a_empty"}, 4'(exp_a.size()), 4'd0);
    chk({tag, "_b_empty"}, 4'(exp_b.size()), 4'd0);
    chk({tag, "_a_qv_low"}, {3'b0, ia.QV}, 4'd0);
    chk({tag, "_b_qv_low"}, {3'b0, ib.QV}, 4'd0);
  endtask

  logic [3:0] q_exp_a1 [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
  logic [3:0] q_exp_b1 [4] = '{4'd0, 4'd0, 4'd0, 4'd1};
  logic [3:0] q_exp_s  [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};

  initial begin
    RN = 1'b0;
    drive_a(1'b0, 4'h0, 1'b1);
    drive_b(1'b0, 4'h0, 1'b1);
    @(negedge CK);
    step();
    step();

    // Reset state
    chk("rst_a_qv",    {3'b0, ia.QV}, 4'd0);
    chk("rst_a_q",     {3'b0, ia.Q},  4'd0);
    chk("rst_a_ql",    {3'b0, ia.QL}, 4'd0);
    chk("rst_a_dr",    {3'b0, ia.DR}, 4'd1);
    chk("rst_a_sl",    {2'b0, ia.SL1, ia.SL0}, 4'd0);
    chk("rst_a_state", {3'b0, state_a}, {3'b0, IDLE});
    chk("rst_b_dr",    {3'b0, ib.DR}, 4'd1);
    chk("rst_b_sl",    {2'b0, ib.SL1, ib.SL0}, 4'd3);
    RN = 1'b1;
    step();

    // Single word, LSB first, 2-cycle first-bit latency
    drive_a(1'b1, 4'b1010, 1'b1);
    step();
    chk("single_lat0_qv", {3'b0, ia.QV}, 4'd0);
    drive_a(1'b0, 4'h0, 1'b1);
    step();
    chk("single_lat1_qv", {3'b0, ia.QV}, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_qv", {3'b0, ia.QV}, 4'd1);
      chk("single_q",  {3'b0, ia.Q},  q_exp_a1[i]);
      chk("single_ql", {3'b0, ia.QL}, {3'b0, (i == 3)});
    end
    step();
    chk("single_end_qv", {3'b0, ia.QV}, 4'd0);
    chk("single_end_state", {3'b0, state_a}, {3'b0, IDLE});

    // Bit order MSB first on B (DEPTH=1)
    drive_b(1'b1, 4'b0001, 1'b1);
    step();
    chk("order_dr_full", {3'b0, ib.DR}, 4'd0);
    drive_b(1'b0, 4'h0, 1'b1);
    step();
    chk("order_lat_qv", {3'b0, ib.QV}, 4'd0);
    for (int i = 0; i < 4; i++) begin
      chk("order_sl", {2'b0, ib.SL1, ib.SL0}, 4'(3 - i));
      step();
      chk("order_q",  {3'b0, ib.Q},  q_exp_b1[i]);
      chk("order_ql", {3'b0, ib.QL}, {3'b0, (i == 3)});
      chk("order_dr", {3'b0, ib.DR}, {3'b0, (i == 3)});
    end
    step();

    // Backpressure after the 2nd bit of 4'b1100
    drive_a(1'b1, 4'b1100, 1'b1);
    step();
    drive_a(1'b0, 4'h0, 1'b1);
    step();
    step();
    chk("bp_bit0", {3'b0, ia.Q}, 4'd0);
    step();
    chk("bp_bit1", {3'b0, ia.Q}, 4'd0);
    drive_a(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_qv", {3'b0, ia.QV}, 4'd1);
      chk("bp_hold_q",  {3'b0, ia.Q},  4'd0);
      chk("bp_hold_ql", {3'b0, ia.QL}, 4'd0);
      chk("bp_hold_sl", {2'b0, ia.SL1, ia.SL0}, 4'd2);
    end
    drive_a(1'b0, 4'h0, 1'b1);
    step();
    chk("bp_resume2", {2'b0, ia.QL, ia.Q}, 4'b0001);
    step();
    chk("bp_resume3", {2'b0, ia.QL, ia.Q}, 4'b0011);
    step();

    // Full buffer: three words offered with QR=0
    drive_a(1'b1, 4'h3, 1'b0);
    step();
    chk("full_dr_1", {3'b0, ia.DR}, 4'd1);
    drive_a(1'b1, 4'h5, 1'b0);
    step();
    chk("full_dr_2", {3'b0, ia.DR}, 4'd0);
    drive_a(1'b1, 4'h9, 1'b0);
    step();
    chk("full_first_qv", {3'b0, ia.QV}, 4'd1);
    chk("full_first_q",  {3'b0, ia.Q},  4'd1);
    step();
    step();
    chk("full_dr_held", {3'b0, ia.DR}, 4'd0);
    drive_a(1'b1, 4'h9, 1'b1);
    step();
    step();
    chk("full_dr_prepop", {3'b0, ia.DR}, 4'd0);
    step();
    chk("full_pop_ql", {3'b0, ia.QL}, 4'd1);
    chk("full_dr_postpop", {3'b0, ia.DR}, 4'd1);
    step();
    drain("full");

    // Streaming 4'hF then 4'h0
    drive_a(1'b1, 4'hF, 1'b1);
    step();
    drive_a(1'b1, 4'h0, 1'b1);
    step();
    drive_a(1'b0, 4'h0, 1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("stream_qv", {3'b0, ia.QV}, 4'd1);
      chk("stream_q",  {3'b0, ia.Q},  q_exp_s[i]);
      step();
    end
    chk("stream_end_qv", {3'b0, ia.QV}, 4'd0);

    // Reset mid-word
    drive_a(1'b1, 4'b0110, 1'b1);
    step();
    drive_a(1'b0, 4'h0, 1'b1);
    step();
    step();
    step();
    chk("midrst_bit1", {3'b0, ia.Q}, 4'd1);
    RN = 1'b0;
    step();
    chk("midrst_qv",    {3'b0, ia.QV}, 4'd0);
    chk("midrst_dr",    {3'b0, ia.DR}, 4'd1);
    chk("midrst_sl",    {2'b0, ia.SL1, ia.SL0}, 4'd0);
    chk("midrst_state", {3'b0, state_a}, {3'b0, IDLE});
    RN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_stale", {3'b0, ia.QV}, 4'd0);
    end

    // Random traffic on both instances against the queue model
    for (int c = 0; c < 400; c++) begin
      drive_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      drive_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      step();
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
